pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generalised inter-stage pipeline register replacing the fixed per-field flop banks between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a parametrised data payload and a control payload with a valid/ready handshake, synchronous flush and an optional skid entry.
- The skid entry lets upstream keep issuing for one cycle after downstream stalls, so the ready path is registered.
- Counts downstream stall cycles for performance debug.

Parameters:
- DATA_W, 64, width of data payload (pc+1, operands, immediates, out data).
- CTRL_W, 24, width of control payload (ALU op, mux selects, write enables, halt); all-zero encodes a NOP.
- SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream consumes the presented entry this cycle.
- out_data  out  DATA_W  presented data payload.
- out_ctrl  out  CTRL_W  presented control; all zero whenever out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes: transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- Reset (async): state EMPTY, main and skid registers all zero, stall_cnt=0, out_valid=0, in_ready=1 (SKID=1).
- Latency: an accepted entry appears on out_* on the next cycle. Throughput is one entry per cycle while out_ready=1.
- Output invariants: out_* always driven from the main register. out_ctrl is gated to zero when not valid, so a bubble is a NOP.
- States (SKID=1): EMPTY, FULL (main valid), SKID_FULL (main and skid valid). in_ready = (state != SKID_FULL) & !flush. in_ready is a registered decode plus flush gating.
- EMPTY: in_valid -> FULL, main<=in.
- FULL:
  - in_valid & out_ready -> FULL, main<=in.
  - !in_valid & out_ready -> EMPTY.
  - in_valid & !out_ready -> SKID_FULL, skid<=in.
  - otherwise hold.
- SKID_FULL: out_ready -> FULL, main<=skid. Otherwise hold. No input is accepted.
- SKID=0: no SKID_FULL state. in_ready = (!out_valid | out_ready) & !flush. Transitions otherwise identical.
- flush has priority over every other event. Next state is EMPTY and main/skid valid and ctrl are cleared.
- flush with in_valid=1: the input is not accepted (in_ready=0). Upstream is responsible for dropping its own entry.
- flush with out_ready=1: the presented entry still counts as consumed that cycle.
- Data registers load only on a transfer (enable-gated); they are not cleared except by reset.
- stall_cnt: increments when out_valid & !out_ready and saturates at 2^CNT_W-1 with no wrap. It is not cleared by flush.
- Reset mid-transfer: all state is dropped immediately and no partial entry survives.

Decomposition:
- Shared package pipe_pkg holds:
  - stage_state_t enum {EMPTY, FULL, SKID_FULL};
  - NOP_CTRL constant (all zero);
  - the default widths, so per-stage instances share one definition.
- One sub-module, pipe_entry_reg: a width-parametrised enable/clear register with async reset and a valid bit. It is instantiated for main and for skid (skid generated only when SKID=1).

Test Plan:
- Reset, then in_valid=1 in_data=0x1234 in_ctrl=0x5, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_ctrl=0x5. Streaming 8 entries gives 8 consecutive outputs in order.
- SKID=1, stream A,B, drop out_ready after A is presented:
  - B lands in skid and in_ready=0 the following cycle;
  - raising out_ready yields A then B with no loss or duplicate;
  - stall_cnt equals the number of low-ready cycles.
- SKID=0, same stimulus -> in_ready falls combinationally in the same cycle out_ready=0 with out_valid=1. No entry is lost.
- State SKID_FULL, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Later entries emerge normally.
- flush together with in_valid=1 in EMPTY -> in_ready=0 that cycle and out_valid stays 0.
- CNT_W=4, out_ready held low 20 cycles with out_valid=1 -> stall_cnt saturates at 15. Assert reset mid-stream -> all outputs zero and stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers.
// Holds the stage state encoding, the NOP control word and default payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } stage_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 24;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_CTRL_W = 256;

  // All-zero control decodes as a NOP in every stage; sliced to CTRL_W at use.
  localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// Purpose: one pipeline entry (data, control, valid) with load/drop/clear controls.
// Latency: loaded values visible the cycle after load.
// Backpressure: none; the owning stage decides when to load or drop.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear kills valid and control only; data is left stale since ctrl gating hides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld  <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      ctrl <= NOP_CTRL[CTRL_W-1:0];
    end else if (load) begin
      vld  <= 1'b1;
      data <= ld_data;
      ctrl <= ld_ctrl;
    end else if (drop) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose: valid/ready pipeline register between core stages, optional skid entry, stall counter.
// Latency: one cycle in to out; one entry per cycle while out_ready is high.
// Backpressure: SKID=1 registered in_ready (absorbs one extra entry); SKID=0 combinational.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_state_t state, state_nxt;
  logic         in_rdy_q;
  logic         in_fire;
  logic         main_ld, main_from_skid, main_drop;
  logic         skid_ld, skid_drop;

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;

  assign in_ready = ((SKID != 0) ? in_rdy_q : (!main_vld || out_ready)) && !flush;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_ld        = 1'b0;
    skid_drop      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          main_ld   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (in_fire) begin
            main_ld = 1'b1;
          end else begin
            main_drop = 1'b1;
            state_nxt = EMPTY;
          end
        end else if (in_fire && (SKID != 0)) begin
          skid_ld   = 1'b1;
          state_nxt = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (out_ready && skid_vld) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_nxt      = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // in_ready is decoded from the next state so the upstream-facing path is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      in_rdy_q <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_rdy_q <= (state_nxt != SKID_FULL);
    end
  end

  assign main_ld_data = main_from_skid ? skid_data : in_data;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (main_ld),
    .drop    (main_drop),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .vld     (main_vld),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (skid_ld),
      .drop    (skid_drop),
      .ld_data (in_data),
      .ld_ctrl (in_ctrl),
      .vld     (skid_vld),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_vld  = 1'b0;
    assign skid_data = '0;
    assign skid_ctrl = '0;
  end

  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_vld ? main_ctrl : NOP_CTRL[CTRL_W-1:0];

  // Saturating; deliberately survives flush so redirect-heavy code still shows stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1, SKID=0 and a CNT_W=4 instance share one stimulus
// stream; each is tracked by a queue-level reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [23:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [23:0] in_ctrl;

  logic        o_vld [3];
  logic        i_rdy [3];
  logic [63:0] o_data [3];
  logic [23:0] o_ctrl [3];
  logic [15:0] st0, st1;
  logic [3:0]  st2;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        mem [3][2];
  int          n [3];
  int unsigned mst [3];
  int unsigned mmax [3] = '{65535, 65535, 15};
  bit          mskid [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(24), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(i_rdy[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_vld[0]), .out_ready(out_ready),
    .out_data(o_data[0]), .out_ctrl(o_ctrl[0]), .stall_cnt(st0)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(24), .SKID(0), .CNT_W(16)) u_dut_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(i_rdy[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_vld[1]), .out_ready(out_ready),
    .out_data(o_data[1]), .out_ctrl(o_ctrl[1]), .stall_cnt(st1)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(24), .SKID(1), .CNT_W(4)) u_dut_cnt4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(i_rdy[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_vld[2]), .out_ready(out_ready),
    .out_data(o_data[2]), .out_ctrl(o_ctrl[2]), .stall_cnt(st2)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_st(input int k);
    case (k)
      0:       return {48'd0, st0};
      1:       return {48'd0, st1};
      default: return {60'd0, st2};
    endcase
  endfunction

  function automatic bit exp_rdy(input int k);
    if (flush) return 1'b0;
    if (mskid[k]) return (n[k] < 2);
    return (n[k] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      n[k]   = 0;
      mst[k] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d out_valid", k), {63'd0, o_vld[k]}, {63'd0, n[k] > 0});
      if (n[k] > 0) begin
        chk($sformatf("k%0d out_data", k), o_data[k], mem[k][0].d);
        chk($sformatf("k%0d out_ctrl", k), {40'd0, o_ctrl[k]}, {40'd0, mem[k][0].c});
      end else begin
        chk($sformatf("k%0d out_ctrl nop", k), {40'd0, o_ctrl[k]}, 64'd0);
      end
      chk($sformatf("k%0d in_ready", k), {63'd0, i_rdy[k]}, {63'd0, exp_rdy(k)});
      chk($sformatf("k%0d stall_cnt", k), dut_st(k), 64'(mst[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit rdy;
      int nb;
      rdy = exp_rdy(k);
      nb  = n[k];
      if (nb > 0 && !out_ready) mst[k] = (mst[k] == mmax[k]) ? mmax[k] : mst[k] + 1;
      if (nb > 0 && out_ready) begin
        mem[k][0] = mem[k][1];
        n[k]--;
      end
      if (flush) n[k] = 0;
      else if (in_valid && rdy) begin
        mem[k][n[k]] = ent_t'{d: in_data, c: in_ctrl};
        n[k]++;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic iv, input logic [63:0] d, input logic [23:0] c,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] s0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    model_reset();
    #1;
    chk("reset out_valid", {63'd0, o_vld[0]}, 64'd0);
    chk("reset in_ready", {63'd0, i_rdy[0]}, 64'd1);
    chk("reset stall_cnt", dut_st(0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First transfer and an 8-entry stream.
    step(1'b1, 64'h1234, 24'h5, 1'b1, 1'b0);
    chk("first out_valid", {63'd0, o_vld[0]}, 64'd1);
    chk("first out_data", o_data[0], 64'h1234);
    chk("first out_ctrl", {40'd0, o_ctrl[0]}, 64'h5);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h100 + 64'(i), 24'(i + 1), 1'b1, 1'b0);
      chk("stream order", o_data[0], 64'h100 + 64'(i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Skid absorbs B when downstream stalls behind A.
    s0 = dut_st(0);
    step(1'b1, 64'hAAAA, 24'hA, 1'b1, 1'b0);
    step(1'b1, 64'hBBBB, 24'hB, 1'b0, 1'b0);
    chk("skid in_ready low", {63'd0, i_rdy[0]}, 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("skid A held", o_data[0], 64'hAAAA);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("skid B next", o_data[0], 64'hBBBB);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("skid stall count", dut_st(0), s0 + 64'd3);

    // Flush from SKID_FULL.
    step(1'b1, 64'hC0C0, 24'hC, 1'b1, 1'b0);
    step(1'b1, 64'hD0D0, 24'hD, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush out_valid", {63'd0, o_vld[0]}, 64'd0);
    chk("flush out_ctrl", {40'd0, o_ctrl[0]}, 64'd0);
    chk("flush in_ready", {63'd0, i_rdy[0]}, 64'd1);
    step(1'b1, 64'hE0E0, 24'hE, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with in_valid in EMPTY.
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 64'hF0F0, 24'hF, 1'b1, 1'b1);
    chk("flush drop input", {63'd0, o_vld[0]}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, 24'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    // Saturation of the 4-bit counter.
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b1, 64'h5A5A, 24'h3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("cnt4 saturate", dut_st(2), 64'd15);

    // Asynchronous reset mid-stream, checked before any clock edge.
    in_valid = 1'b1; in_data = 64'h7777; in_ctrl = 24'h7; out_ready = 1'b0; flush = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("k%0d arst out_valid", k), {63'd0, o_vld[k]}, 64'd0);
      chk($sformatf("k%0d arst out_data", k), o_data[k], 64'd0);
      chk($sformatf("k%0d arst out_ctrl", k), {40'd0, o_ctrl[k]}, 64'd0);
      chk($sformatf("k%0d arst stall_cnt", k), dut_st(k), 64'd0);
      chk($sformatf("k%0d arst in_ready", k), {63'd0, i_rdy[k]}, 64'd1);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 64'h900 + 64'(i), 24'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
